// File: rtl/ysyx_040729_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a one-outstanding request/response port.
// Optional CLINT_DEBUG_HALT_EN adds a debug_halt input that freezes the prescaler and mtime.
module ysyx_040729_clint #(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 64'h0000_0000_0200_0000,
  parameter int                    TICK_DIV   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
`ifdef CLINT_DEBUG_HALT_EN
  input  logic                      debug_halt,
`endif
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [DATA_WIDTH-1:0]     req_addr,
  input  logic                      req_wen,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err,
  output logic                      tirp_o,
  output logic                      sirp_o,
  output logic                      dbg_state
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] OFF_MSIP     = '0;
  localparam logic [DATA_WIDTH-1:0] OFF_MTIMECMP = DATA_WIDTH'(17'h0_4000);
  localparam logic [DATA_WIDTH-1:0] OFF_MTIME    = DATA_WIDTH'(17'h0_bff8);
  localparam logic [DATA_WIDTH-1:0] WIN_SIZE     = DATA_WIDTH'(17'h1_0000);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready.
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
  state_t state, state_d;

  logic [DATA_WIDTH-1:0] mtime, mtimecmp, mtime_inc, mtime_d;
  logic [DATA_WIDTH-1:0] offset, wmask, rdata_sel;
  logic [15:0]           presc;
  logic                  msip, run, tick;
  logic                  in_win, aligned, sel_msip, sel_cmp, sel_time, dec_err;
  logic                  accept, wr_msip, wr_cmp, wr_time;

  assign offset   = req_addr - BASE_ADDR;
  assign in_win   = (req_addr >= BASE_ADDR) && (offset < WIN_SIZE);
  assign aligned  = (req_addr[2:0] == 3'b000);
  assign sel_msip = in_win && aligned && (offset == OFF_MSIP);
  assign sel_cmp  = in_win && aligned && (offset == OFF_MTIMECMP);
  assign sel_time = in_win && aligned && (offset == OFF_MTIME);
  assign dec_err  = !(sel_msip || sel_cmp || sel_time);

  assign accept  = (state == IDLE) && req_valid;
  assign wr_msip = accept && req_wen && sel_msip;
  assign wr_cmp  = accept && req_wen && sel_cmp;
  assign wr_time = accept && req_wen && sel_time;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < SW; i++) wmask[8*i +: 8] = {8{req_wstrb[i]}};
  end

`ifdef CLINT_DEBUG_HALT_EN
  assign run = !debug_halt;
`else
  assign run = 1'b1;
`endif

  // Terminal count of the prescaler; with TICK_DIV=1 the counter sits at 0 and ticks every cycle.
  assign tick      = run && (presc == 16'(TICK_DIV - 1));
  assign mtime_inc = mtime + {{(DATA_WIDTH-1){1'b0}}, tick};
  // Written bytes win over the tick; unwritten bytes still advance.
  assign mtime_d   = wr_time ? ((req_wdata & wmask) | (mtime_inc & ~wmask)) : mtime_inc;

  always_comb begin
    rdata_sel = '0;
    if (sel_msip)      rdata_sel = {{(DATA_WIDTH-1){1'b0}}, msip};
    else if (sel_cmp)  rdata_sel = mtimecmp;
    else if (sel_time) rdata_sel = mtime;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_valid)  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign dbg_state  = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (wr_time) begin
      presc <= '0;
    end else if (run) begin
      presc <= tick ? 16'd0 : presc + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
      tirp_o   <= 1'b0;
    end else begin
      mtime  <= mtime_d;
      tirp_o <= (mtime >= mtimecmp);
      if (wr_cmp)                  mtimecmp <= (req_wdata & wmask) | (mtimecmp & ~wmask);
      if (wr_msip && req_wstrb[0]) msip     <= req_wdata[0];
    end
  end

  assign sirp_o = msip;

  // Read data is taken from pre-write register values at the accepting edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_rdata <= req_wen ? '0 : rdata_sel;
      resp_err   <= dec_err;
    end
  end

endmodule

// File: tb/tb_ysyx_040729_clint.sv
// Bench for ysyx_040729_clint (TICK_DIV=4): directed register-map scenarios plus random traffic,
// all checked every cycle against a time-based model of mtime and the register map.
module tb_ysyx_040729_clint;

  localparam int          TD   = 4;
  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        tirp_o, sirp_o, dbg_state;

  ysyx_040729_clint #(.DATA_WIDTH(64), .BASE_ADDR(BASE), .TICK_DIV(TD)) dut (
    .clock(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .tirp_o(tirp_o), .sirp_o(sirp_o), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mtime is a function of elapsed edges: base + (edges since last mtime write) / TD.
  logic [63:0] m_base, m_cmp;
  longint      m_ref, m_k, m_acc_k;
  bit          m_msip, m_busy, m_tirp;
  logic [64:0] exp_q[$];

  function automatic logic [63:0] mt_at(input longint k);
    return m_base + 64'((k - m_ref) / TD);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] w, input logic [63:0] old,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_base = '0; m_ref = 0; m_k = 0; m_acc_k = 0;
      m_cmp = '1; m_msip = 0; m_busy = 0; m_tirp = 0;
      exp_q.delete();
    end else begin
      logic [63:0] off, pre, rd;
      bit          err;
      int          which;
      m_k++;
      pre    = mt_at(m_k - 1);
      m_tirp = (pre >= m_cmp);
      if (m_busy) begin
        if (resp_ready) begin
          m_busy = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else if (req_valid) begin
        off   = req_addr - BASE;
        which = -1;
        if (req_addr >= BASE && off < 64'h1_0000 && req_addr[2:0] == 3'b0) begin
          if (off == 64'h0)         which = 0;
          else if (off == 64'h4000) which = 1;
          else if (off == 64'hBFF8) which = 2;
        end
        err = (which < 0);
        rd  = '0;
        if (!req_wen) begin
          if (which == 0)      rd = {63'b0, m_msip};
          else if (which == 1) rd = m_cmp;
          else if (which == 2) rd = pre;
        end else begin
          if (which == 0 && req_wstrb[0]) m_msip = req_wdata[0];
          if (which == 1) m_cmp = merge(req_wdata, m_cmp, req_wstrb);
          if (which == 2) begin
            m_base = merge(req_wdata, mt_at(m_k), req_wstrb);
            m_ref  = m_k;
          end
        end
        exp_q.push_back({err, rd});
        m_busy  = 1;
        m_acc_k = m_k;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", req_ready, !m_busy);
      check("resp_valid", resp_valid, m_busy);
      check("tirp", tirp_o, m_tirp);
      check("sirp", sirp_o, m_msip);
      if (m_busy && exp_q.size() > 0) begin
        check("resp_rdata", resp_rdata, exp_q[0][63:0]);
        check("resp_err", resp_err, exp_q[0][64]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                        input logic [7:0] strb, output logic [63:0] rdata, output logic err);
    bit ok;
    rdata = '0; err = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_wen = wen; req_wdata = wdata; req_wstrb = strb;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      check("resp_timeout", 0, 1);
      return;
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rdata = resp_rdata; err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] r; logic e;
    do_req(addr, 1'b1, d, s, r, e);
  endtask

  task automatic rd(input logic [63:0] addr, output logic [63:0] r, output logic e);
    do_req(addr, 1'b0, {$urandom, $urandom}, 8'hFF, r, e);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] r;
    logic        e;
    longint      wk;
    bit          seen;
    logic [63:0] a;
    rst_n = 1'b0; req_valid = 0; req_addr = 0; req_wen = 0; req_wdata = 0; req_wstrb = 0;
    resp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_tirp", tirp_o, 0);
    check("rst_sirp", sirp_o, 0);
    rst_n = 1'b1;

    // reset values
    rd(BASE + 64'hBFF8, r, e);
    check("rst_mtime_small", (r < 64'd8), 1);
    check("rst_mtime_err", e, 0);
    rd(BASE + 64'h4000, r, e);
    check("rst_mtimecmp", r, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(BASE, r, e);
    check("rst_msip", r, 64'h0);

    // timer fire: mtime reaches 10 after 40 edges, tirp follows one edge later
    wr(BASE + 64'hBFF8, 64'h0, 8'hFF);
    wk = m_acc_k;
    wr(BASE + 64'h4000, 64'd10, 8'hFF);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tirp_o) begin seen = 1; break; end
    end
    check("tirp_rise_seen", seen, 1);
    check("tirp_rise_latency", 64'(m_k - wk), 64'd41);
    wr(BASE + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    check("tirp_fall", tirp_o, 0);

    // partial write and wrap
    wr(BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    wr(BASE + 64'h4000, 64'h55, 8'h01);
    rd(BASE + 64'h4000, r, e);
    check("cmp_partial", r, 64'hFFFF_FFFF_FFFF_FF55);
    repeat (20) @(negedge clk);
    rd(BASE + 64'hBFF8, r, e);
    check("mtime_wrapped_small", (r < 64'd16), 1);
    check("tirp_after_wrap", tirp_o, 0);

    // msip
    wr(BASE, 64'hFFFF_FFFF, 8'hFF);
    check("sirp_set", sirp_o, 1);
    rd(BASE, r, e);
    check("msip_read", r, 64'h1);
    wr(BASE, 64'h0, 8'hFF);
    check("sirp_clr", sirp_o, 0);

    // errors
    rd(BASE + 64'h4, r, e);
    check("misaligned_err", e, 1);
    check("misaligned_data", r, 0);
    rd(BASE + 64'h1000, r, e);
    check("unmapped_rd_err", e, 1);
    check("unmapped_rd_data", r, 0);
    do_req(BASE + 64'h1000, 1'b1, 64'h1234, 8'hFF, r, e);
    check("unmapped_wr_err", e, 1);
    do_req(BASE + 64'h4000 - 64'h8, 1'b1, 64'h1, 8'hFF, r, e);
    check("unmapped_wr2_err", e, 1);
    rd(BASE + 64'h4000, r, e);
    check("cmp_unchanged", r, 64'hFFFF_FFFF_FFFF_FF55);

    // backpressure: A held for 5 cycles while B waits
    @(posedge clk); #1;
    req_valid = 1; req_addr = BASE + 64'h4000; req_wen = 0; req_wstrb = 8'hFF;
    @(posedge clk); #1;
    req_addr = BASE; req_wen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_rdata_held", resp_rdata, 64'hFFFF_FFFF_FFFF_FF55);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    @(negedge clk);
    check("bp_idle_again", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    check("bp_b_resp_valid", resp_valid, 1);
    check("bp_b_rdata", resp_rdata, 64'h0);
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;

    // random traffic
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0:       a = BASE;
        1, 2:    a = BASE + 64'h4000;
        3, 4:    a = BASE + 64'hBFF8;
        5:       a = BASE + 64'($urandom_range(1, 7)) + 64'h4000;
        6:       a = BASE + 64'($urandom_range(0, 16'hFFFF)) & ~64'h7;
        default: a = ($urandom_range(0, 1) != 0) ? BASE + 64'h1_0000 : BASE - 64'h8;
      endcase
      if ($urandom_range(0, 1) != 0)
        do_req(a, 1'b1,
               ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 40)),
               ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom_range(0, 255)), r, e);
      else
        rd(a, r, e);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
